// File: rtl/c2hdl_ram_slave.sv
// Multi-port byte-addressed RAM slave: round-robin arbitration, one access in flight.
// Define C2HDL_RAM_ERR_EN to enable range/alignment error checking.
module c2hdl_ram_slave #(
  parameter int unsigned NP    = 2,
  parameter logic [31:0] BASE  = 32'h1000,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned LAT   = 1
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [NP-1:0]     valid,
  input  logic [NP-1:0]     write,
  input  logic [3*NP-1:0]   size,
  input  logic [32*NP-1:0]  addr,
  input  logic [32*NP-1:0]  wdata,
  output logic [NP-1:0]     ready,
  output logic [31:0]       rdata,
  output logic [NP-1:0]     err
);

  localparam int unsigned GW       = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  BusyInit = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StTurn} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;

  logic [7:0]    mem [DEPTH];

  logic          req_found;
  logic [GW-1:0] req_idx;
  logic [31:0]   off_full;
  logic [AW-1:0] off;
  logic [2:0]    nbytes;
  logic          nop_c, err_c, wr_en, resp_load;
  logic [31:0]   wsh, rd_word, rd_val;

  // Round-robin search starting at the port after the last grant.
  always_comb begin
    int unsigned idx;
    logic [GW-1:0] cand;
    idx       = 0;
    cand      = '0;
    req_found = 1'b0;
    req_idx   = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NP) idx = idx - NP;
      cand = GW'(idx);
      if (!req_found && valid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Decode of the latched request.
  assign off_full = addr_q - BASE;
  assign off      = off_full[AW-1:0];
  assign nop_c    = (size_q > 3'd2);
  assign wsh      = wdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (size_q)
      3'd0:    nbytes = 3'd1;
      3'd1:    nbytes = 3'd2;
      3'd2:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

`ifdef C2HDL_RAM_ERR_EN
  assign err_c = nop_c
               || (off_full > (DEPTH - 32'(nbytes)))
               || ((size_q == 3'd1) && addr_q[0])
               || ((size_q == 3'd2) && (addr_q[1:0] != 2'b00));
`else
  logic unused_off;
  assign unused_off = ^off_full[31:AW];
  assign err_c      = 1'b0;
`endif

  assign wr_en     = write_q && !nop_c && !err_c;
  assign rd_word   = {mem[{off[AW-1:2], 2'd3}], mem[{off[AW-1:2], 2'd2}],
                      mem[{off[AW-1:2], 2'd1}], mem[{off[AW-1:2], 2'd0}]};
  assign rd_val    = (nop_c || err_c) ? 32'd0 : rd_word;
  // Writes only touch rdata when they complete as a no-op or error (forced 0).
  assign resp_load = (state_q == StResp) && (!write_q || nop_c || err_c);
  assign rdata     = resp_load ? rd_val : rdata_q;

  always_comb begin
    ready = '0;
    if (state_q == StResp) ready[gnt_q] = 1'b1;
  end

`ifdef C2HDL_RAM_ERR_EN
  assign err = ready & {NP{err_c}};
`else
  assign err = '0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = rdata;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          gnt_d   = req_idx;
          ptr_d   = (req_idx == GW'(NP - 1)) ? '0 : req_idx + 1'b1;
          addr_d  = addr[req_idx*32 +: 32];
          wdata_d = wdata[req_idx*32 +: 32];
          size_d  = size[req_idx*3 +: 3];
          write_d = write[req_idx];
          if (LAT <= 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = BusyInit;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; a reset forces StIdle so no commit follows.
  always_ff @(posedge clk) begin
    if ((state_q == StResp) && wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(nbytes)) mem[off + AW'(k)] <= wsh[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_c2hdl_ram_slave.sv
// Scoreboard bench for c2hdl_ram_slave: one LAT=1 and one LAT=4 instance, NP=2.
module tb_c2hdl_ram_slave;

  localparam bit ErrEn =
`ifdef C2HDL_RAM_ERR_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    int          d;
    int          p;
    logic [31:0] rd;
    bit          chk;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic [1:0]  valid_s [2];
  logic [1:0]  write_s [2];
  logic [5:0]  size_s  [2];
  logic [63:0] addr_s  [2];
  logic [63:0] wdata_s [2];
  logic [3:0]  ready_all;
  logic [3:0]  err_all;
  logic [63:0] rdata_all;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  c2hdl_ram_slave #(.NP(2), .BASE(32'h1000), .DEPTH(4096), .LAT(1)) u_dut_l1 (
    .clk   (clk),
    .rstb  (rstb),
    .valid (valid_s[0]),
    .write (write_s[0]),
    .size  (size_s[0]),
    .addr  (addr_s[0]),
    .wdata (wdata_s[0]),
    .ready (ready_all[1:0]),
    .rdata (rdata_all[31:0]),
    .err   (err_all[1:0])
  );

  c2hdl_ram_slave #(.NP(2), .BASE(32'h1000), .DEPTH(4096), .LAT(4)) u_dut_l4 (
    .clk   (clk),
    .rstb  (rstb),
    .valid (valid_s[1]),
    .write (write_s[1]),
    .size  (size_s[1]),
    .addr  (addr_s[1]),
    .wdata (wdata_s[1]),
    .ready (ready_all[3:2]),
    .rdata (rdata_all[63:32]),
    .err   (err_all[3:2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d, input int p, input logic [31:0] rd, input bit chk,
                          input logic er);
    exp_t e;
    e.d = d; e.p = p; e.rd = rd; e.chk = chk; e.er = er;
    sb.push_back(e);
  endtask

  // Single access; request inputs are scrambled after the grant edge.
  task automatic access(input int d, input int p, input bit w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit chk, input bit exp_er, input int exp_lat);
    int cyc;
    bit got;
    push_exp(d, p, exp_rd, chk, exp_er);
    write_s[d][p]          = w;
    size_s[d][3*p +: 3]    = sz;
    addr_s[d][32*p +: 32]  = a;
    wdata_s[d][32*p +: 32] = wd;
    valid_s[d][p]          = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        addr_s[d][32*p +: 32]  = $urandom;
        wdata_s[d][32*p +: 32] = $urandom;
        write_s[d][p]          = ~w;
      end
      @(negedge clk);
      got = ready_all[2*d+p];
    end
    check_eq("latency", cyc, exp_lat);
    valid_s[d][p] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (ready_all[2*d+p] === 1'b1) begin
          if (sb.size() == 0) begin
            check_eq("spurious_ready", 32'(ready_all), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("ready_dut", d, e.d);
            check_eq("ready_port", p, e.p);
            check_eq("err", 32'(err_all[2*d+p]), 32'(e.er));
            if (e.chk) check_eq("rdata", rdata_all[32*d +: 32], e.rd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int left [2];
    bit got;

    for (int d = 0; d < 2; d++) begin
      valid_s[d] = '0; write_s[d] = '0; size_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    rstb = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ready_all), 32'd0);
    check_eq("rst_err", 32'(err_all), 32'd0);
    check_eq("rst_rdata0", rdata_all[31:0], 32'd0);
    check_eq("rst_rdata1", rdata_all[63:32], 32'd0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Basic word write/read, then byte merge.
    access(0, 0, 1, 3'd2, 32'h1010, 32'hdeadbeef, 32'h0, 0, 0, 1);
    access(0, 0, 0, 3'd2, 32'h1010, 32'h0, 32'hdeadbeef, 1, 0, 1);
    access(0, 0, 1, 3'd0, 32'h1013, 32'hab000000, 32'h0, 0, 0, 1);
    access(0, 0, 0, 3'd2, 32'h1010, 32'h0, 32'habadbeef, 1, 0, 1);

    // size=3: completes, no storage change, rdata 0.
    access(0, 0, 0, 3'd3, 32'h1010, 32'h0, 32'h0, 1, ErrEn, 1);
    access(0, 0, 1, 3'd3, 32'h1010, 32'hffffffff, 32'h0, 1, ErrEn, 1);
    access(0, 0, 0, 3'd2, 32'h1010, 32'h0, 32'habadbeef, 1, 0, 1);

    // Port 1 traffic with half-word merge; leaves the pointer at port 0.
    access(0, 1, 1, 3'd2, 32'h1014, 32'hcafef00d, 32'h0, 0, 0, 1);
    access(0, 1, 1, 3'd1, 32'h1016, 32'h5a5a0000, 32'h0, 0, 0, 1);
    access(0, 1, 0, 3'd2, 32'h1014, 32'h0, 32'h5a5af00d, 1, 0, 1);

    // Both ports request together: grants must alternate 0,1,0,1,0,1.
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 0, 32'habadbeef, 1, 0);
      push_exp(0, 1, 32'h5a5af00d, 1, 0);
    end
    write_s[0] = 2'b00;
    size_s[0]  = {3'd2, 3'd2};
    addr_s[0]  = {32'h1014, 32'h1010};
    valid_s[0] = 2'b11;
    left[0] = 3; left[1] = 3; cyc = 0;
    while ((left[0] + left[1]) > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (ready_all[p] === 1'b1 && left[p] > 0) begin
          left[p]--;
          if (left[p] == 0) valid_s[0][p] = 1'b0;
        end
      end
    end
    check_eq("rr_remaining", left[0] + left[1], 0);
    valid_s[0] = 2'b00;
    repeat (2) @(negedge clk);

    // Misaligned word write at 0x1002.
    access(0, 0, 1, 3'd2, 32'h1000, 32'h11111111, 32'h0, 0, 0, 1);
    access(0, 0, 1, 3'd2, 32'h1004, 32'h22222222, 32'h0, 0, 0, 1);
    access(0, 0, 1, 3'd2, 32'h1002, 32'h44332211, 32'h0, ErrEn, ErrEn, 1);
    access(0, 0, 0, 3'd2, 32'h1000, 32'h0, ErrEn ? 32'h11111111 : 32'h44331111, 1, 0, 1);
    access(0, 0, 0, 3'd2, 32'h1004, 32'h0, ErrEn ? 32'h22222222 : 32'h22220000, 1, 0, 1);

    // LAT=4 instance: latency and ready-to-next-grant spacing.
    access(1, 0, 1, 3'd2, 32'h1020, 32'h11223344, 32'h0, 0, 0, 4);
    access(1, 0, 0, 3'd2, 32'h1020, 32'h0, 32'h11223344, 1, 0, 4);
    push_exp(1, 0, 32'h11223344, 1, 0);
    push_exp(1, 0, 32'h11223344, 1, 0);
    write_s[1][0] = 1'b0; size_s[1][2:0] = 3'd2; addr_s[1][31:0] = 32'h1020;
    valid_s[1][0] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        got = ready_all[2];
      end
      check_eq(r == 0 ? "lat4_first" : "lat4_spacing", cyc, r == 0 ? 4 : 6);
    end
    valid_s[1][0] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during BUSY of a write aborts it.
    write_s[1][0] = 1'b1; size_s[1][2:0] = 3'd2;
    addr_s[1][31:0] = 32'h1020; wdata_s[1][31:0] = 32'h55667788;
    valid_s[1][0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rstb = 1'b0;
    valid_s[1][0] = 1'b0;
    #1;
    check_eq("abort_ready", 32'(ready_all), 32'd0);
    check_eq("abort_rdata", rdata_all[63:32], 32'd0);
    repeat (6) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    access(1, 0, 0, 3'd2, 32'h1020, 32'h0, 32'h11223344, 1, 0, 4);

    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
